// File: rtl/burst_write_ram_pkg.sv
// Shared definitions for the burst write RAM: FSM state encoding and default sizes.
package burst_write_ram_pkg;

   localparam int unsigned DEF_AW = 4;   // address width, depth 2**DEF_AW
   localparam int unsigned DEF_DW = 8;   // data word width

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/burst_write_ram_ram.sv
// sp_sync_ram: storage array with one synchronous write port and one
// synchronous read port, each with its own enable. Contents are never reset.
// Ports:
//   clk     - clock, all activity on rising edge
//   we/wa/wd - write enable, write address, write data
//   re/ra    - read enable, read address
//   rd       - registered read data, holds when re=0
module sp_sync_ram
   import burst_write_ram_pkg::*;
#(
   parameter int unsigned AW = DEF_AW,
   parameter int unsigned DW = DEF_DW
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic          re,
   input  logic [AW-1:0] ra,
   output logic [DW-1:0] rd
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];

   // Write and read ports; no reset so the array maps onto a plain RAM macro.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= wd;
      end
      if (re) begin
         rd <= mem[ra];
      end
   end

endmodule

// File: rtl/burst_write_ram.sv
// burst_write_ram: accepts a burst of len words via a valid/ready write
// stream and stores them at consecutive (wrapping) addresses; reads are
// served only while no burst is in progress.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start, start_ad, len - burst request, first address, word count (0..2**AW)
//   wr_valid, wr_data - producer word stream
//   wr_ready          - word accepted this cycle when wr_valid is high
//   busy              - burst in progress (WRITE or DONE)
//   done              - one-cycle completion pulse
//   ad_rd, data_out   - read address, registered read data (one-cycle latency)
module burst_write_ram
   import burst_write_ram_pkg::*;
#(
   parameter int unsigned AW = DEF_AW,
   parameter int unsigned DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] start_ad,
   input  logic [AW:0]   len,
   input  logic          wr_valid,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ready,
   output logic          busy,
   output logic          done,
   input  logic [AW-1:0] ad_rd,
   output logic [DW-1:0] data_out
);

   localparam int unsigned CW = AW + 1;

   state_t        state_q;
   state_t        state_nx;
   logic [AW-1:0] ptr_q;
   logic [CW-1:0] cnt_q;
   logic          accept;
   logic          rd_vld_q;
   logic [DW-1:0] ram_rd;

   assign accept = wr_valid & wr_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_nx = (len == '0) ? ST_DONE : ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (accept && (cnt_q == CW'(1))) begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Outputs decoded from state only
   always_comb begin
      wr_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         ST_WRITE: begin
            wr_ready = 1'b1;
            busy     = 1'b1;
         end
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Burst pointer and remaining-word counter
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else if ((state_q == ST_IDLE) && start && (len != '0)) begin
         ptr_q <= start_ad;
         cnt_q <= len;
      end else if (accept) begin
         ptr_q <= ptr_q + AW'(1);
         cnt_q <= cnt_q - CW'(1);
      end
   end

   // The RAM read register has no reset; this flag masks it to zero until
   // the first read after reset lands, and freezes along with it while busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_q <= 1'b0;
      end else if (!busy) begin
         rd_vld_q <= 1'b1;
      end
   end

   assign data_out = ram_rd & {DW{rd_vld_q}};

   sp_sync_ram #(
      .AW (AW),
      .DW (DW)
   ) u_ram (
      .clk (clk),
      .we  (accept & ~rst),
      .wa  (ptr_q),
      .wd  (wr_data),
      .re  (~busy),
      .ra  (ad_rd),
      .rd  (ram_rd)
   );

endmodule

// File: tb/tb_burst_write_ram.sv
// Bench for burst_write_ram: directed bursts with a due-cycle scoreboard.
module tb_burst_write_ram;

   localparam int F_DATA = 0;
   localparam int F_RDY  = 1;
   localparam int F_BUSY = 2;
   localparam int F_DONE = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] start_ad;
   logic [4:0] len;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       busy;
   logic       done;
   logic [3:0] ad_rd;
   logic [7:0] data_out;

   int cyc     = 0;
   int n_cmp   = 0;
   int n_err   = 0;

   int         due_q [$];
   int         sel_q [$];
   logic [7:0] val_q [$];
   string      tag_q [$];

   burst_write_ram #(.AW(4), .DW(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .start_ad (start_ad),
      .len      (len),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .busy     (busy),
      .done     (done),
      .ad_rd    (ad_rd),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation that falls due at this sample point
   always @(negedge clk) begin
      for (int i = int'(due_q.size()) - 1; i >= 0; i--) begin
         if (due_q[i] <= cyc) begin
            logic [7:0] act;
            case (sel_q[i])
               F_DATA:  act = data_out;
               F_RDY:   act = {7'd0, wr_ready};
               F_BUSY:  act = {7'd0, busy};
               default: act = {7'd0, done};
            endcase
            n_cmp++;
            if (act !== val_q[i] || due_q[i] != cyc) begin
               n_err++;
               $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, due %0d)",
                        tag_q[i], act, val_q[i], cyc, due_q[i]);
            end
            due_q.delete(i);
            sel_q.delete(i);
            val_q.delete(i);
            tag_q.delete(i);
         end
      end
   end

   task automatic go();
      @(negedge clk);
   endtask

   // Expectation for the next sample point
   task automatic expect_nx(input int sel, input logic [7:0] v, input string tag);
      due_q.push_back(cyc + 1);
      sel_q.push_back(sel);
      val_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic exp_st(input logic rdy, input logic bsy, input logic dn, input string tag);
      expect_nx(F_RDY,  {7'd0, rdy}, {tag, "_ready"});
      expect_nx(F_BUSY, {7'd0, bsy}, {tag, "_busy"});
      expect_nx(F_DONE, {7'd0, dn},  {tag, "_done"});
   endtask

   task automatic rd(input logic [3:0] a, input logic [7:0] e, input string tag);
      ad_rd = a;
      expect_nx(F_DATA, e, $sformatf("%s_rd%0d", tag, a));
      go();
   endtask

   // Burst of n words base, base+step, ... with 'gap' idle cycles before each word
   task automatic burst(input logic [3:0] ad, input logic [4:0] n, input logic [7:0] base,
                        input logic [7:0] step, input int gap, input string tag);
      int nw;
      nw       = int'(n);
      start    = 1'b1;
      start_ad = ad;
      len      = n;
      exp_st(1'b1, 1'b1, 1'b0, {tag, "_go"});
      go();
      start = 1'b0;
      for (int i = 0; i < nw; i++) begin
         for (int g = 0; g < gap; g++) begin
            wr_valid = 1'b0;
            exp_st(1'b1, 1'b1, 1'b0, {tag, "_stall"});
            go();
         end
         wr_valid = 1'b1;
         wr_data  = base + step * 8'(i);
         if (i == nw - 1) exp_st(1'b0, 1'b1, 1'b1, {tag, "_last"});
         else             exp_st(1'b1, 1'b1, 1'b0, {tag, "_acc"});
         go();
      end
      wr_valid = 1'b0;
      exp_st(1'b0, 1'b0, 1'b0, {tag, "_idle"});
      go();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start_ad = '0; len = '0;
      wr_valid = 1'b0; wr_data = '0; ad_rd = '0;
      go();
      exp_st(1'b0, 1'b0, 1'b0, "reset");
      expect_nx(F_DATA, 8'h00, "reset_dout");
      go();
      rst = 1'b0;
      go();
      n_cmp++;
      if (wr_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_idle: got rdy=%b busy=%b done=%b expected 0 0 0",
                  wr_ready, busy, done);
      end

      // Back-to-back burst at 0, then reads including final word right after DONE
      burst(4'd0, 5'd4, 8'hA1, 8'h01, 0, "t1");
      rd(4'd3, 8'hA4, "t1_last");
      for (int i = 0; i < 4; i++) rd(4'(i), 8'hA1 + 8'(i), "t1");
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL t1_busy_after_reads: got %b expected 0", busy);
      end

      // Address wrap 14,15,0,1; location 2 untouched
      burst(4'd14, 5'd4, 8'h11, 8'h11, 0, "t2");
      rd(4'd14, 8'h11, "t2");
      rd(4'd15, 8'h22, "t2");
      rd(4'd0,  8'h33, "t2");
      rd(4'd1,  8'h44, "t2");
      rd(4'd2,  8'hA3, "t2");

      // Stalls of 5 cycles between words; location 3 untouched
      burst(4'd0, 5'd3, 8'h31, 8'h01, 5, "t3");
      rd(4'd0, 8'h31, "t3");
      rd(4'd1, 8'h32, "t3");
      rd(4'd2, 8'h33, "t3");
      rd(4'd3, 8'hA4, "t3");

      // Zero-length burst with wr_valid asserted: no writes
      start = 1'b1; start_ad = 4'd0; len = 5'd0; wr_valid = 1'b1; wr_data = 8'hFF;
      exp_st(1'b0, 1'b1, 1'b1, "t4_done");
      go();
      start = 1'b0;
      exp_st(1'b0, 1'b0, 1'b0, "t4_idle");
      go();
      wr_valid = 1'b0;
      rd(4'd0, 8'h31, "t4");
      rd(4'd1, 8'h32, "t4");
      rd(4'd2, 8'h33, "t4");
      rd(4'd3, 8'hA4, "t4");

      // start pulses and ad_rd changes during a burst: ignored, data_out frozen
      start = 1'b1; start_ad = 4'd8; len = 5'd4;
      exp_st(1'b1, 1'b1, 1'b0, "t5a_go");
      go();
      for (int i = 0; i < 4; i++) begin
         start = 1'b1; start_ad = 4'd0; len = 5'd2; ad_rd = 4'(i);
         wr_valid = 1'b1; wr_data = 8'h01 + 8'(i);
         if (i == 3) exp_st(1'b0, 1'b1, 1'b1, "t5a_last");
         else        exp_st(1'b1, 1'b1, 1'b0, "t5a_acc");
         expect_nx(F_DATA, 8'hA4, "t5a_frozen");
         go();
      end
      wr_valid = 1'b0; ad_rd = 4'd5;
      exp_st(1'b0, 1'b0, 1'b0, "t5a_idle");
      expect_nx(F_DATA, 8'hA4, "t5a_frozen_done");
      go();
      start = 1'b0;
      exp_st(1'b0, 1'b0, 1'b0, "t5a_no_restart");
      go();
      for (int i = 0; i < 4; i++) rd(4'd8 + 4'(i), 8'h01 + 8'(i), "t5a");
      rd(4'd0, 8'h31, "t5a");

      // Reset after 2 of 4 words; reset beats start and wr_valid in the same cycle
      start = 1'b1; start_ad = 4'd8; len = 5'd4;
      exp_st(1'b1, 1'b1, 1'b0, "t5b_go");
      go();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wr_valid = 1'b1; wr_data = 8'h81 + 8'(i);
         exp_st(1'b1, 1'b1, 1'b0, "t5b_acc");
         go();
      end
      rst = 1'b1; start = 1'b1; wr_valid = 1'b1; wr_data = 8'h83;
      exp_st(1'b0, 1'b0, 1'b0, "t5b_rst");
      expect_nx(F_DATA, 8'h00, "t5b_rst_dout");
      go();
      rst = 1'b0; start = 1'b0; wr_data = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         exp_st(1'b0, 1'b0, 1'b0, "t5b_post");
         go();
      end
      wr_valid = 1'b0;
      rd(4'd8,  8'h81, "t5b");
      rd(4'd9,  8'h82, "t5b");
      rd(4'd10, 8'h03, "t5b");
      rd(4'd11, 8'h04, "t5b");
      rd(4'd0,  8'h31, "t5b");

      // Full-depth burst starting mid-array
      burst(4'd5, 5'd16, 8'h50, 8'h01, 0, "t6");
      for (int i = 0; i < 16; i++) rd(4'd5 + 4'(i), 8'h50 + 8'(i), "t6");
      n_cmp++;
      if (done !== 1'b0 || wr_ready !== 1'b0) begin
         n_err++;
         $display("FAIL t6_idle_after_reads: got done=%b rdy=%b expected 0 0", done, wr_ready);
      end

      go();
      go();
      while (due_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: got no sample expected 0x%0h", tag_q[0], val_q[0]);
         void'(due_q.pop_front());
         void'(sel_q.pop_front());
         void'(val_q.pop_front());
         void'(tag_q.pop_front());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish by 200000");
      $fatal(1, "timeout");
   end

endmodule
